// File: rtl/egg_timer_pkg.sv
// rtl/egg_timer_pkg.sv - shared state encoding, BCD limits and clamp helper
package egg_timer_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] ONES_MAX     = 4'd9;

  // Saturate an out-of-range preset digit to its legal maximum
  function automatic logic [3:0] clamp_digit(input logic [3:0] value, input logic [3:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - single BCD down-counting digit with load and borrow-out
module bcd_down_digit
  import egg_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       dec,
  input  logic [3:0] max_value,
  output logic [3:0] digit,
  output logic       borrow_out
);

  // Load wins over decrement; decrementing through zero wraps to max_value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= clamp_digit(load_value, max_value);
    end else if (dec) begin
      digit <= (digit == 4'd0) ? max_value : digit - 4'd1;
    end
  end

  // Borrow into the next-more-significant digit when this one wraps
  assign borrow_out = dec && (digit == 4'd0);

endmodule

// File: rtl/egg_timer_countdown.sv
// rtl/egg_timer_countdown.sv - MM:SS BCD countdown with cook_time and timed alarm
module egg_timer_countdown
  import egg_timer_pkg::*;
#(
  parameter int ALARM_CYCLES = 5,
  parameter int MAX_MIN_TENS = 5
) (
  input  logic       pulse_1Hz,
  input  logic       reset_n,
  input  logic       enable_load,
  input  logic [3:0] load_second_ones,
  input  logic [3:0] load_second_tens,
  input  logic [3:0] load_minute_ones,
  input  logic [3:0] load_minute_tens,
  input  logic       enable_timer_countdown,
  output logic [3:0] second_ones,
  output logic [3:0] second_tens,
  output logic [3:0] minute_ones,
  output logic [3:0] minute_tens,
  output logic       cook_time,
  output logic       alarm,
  output logic       running
);

  localparam logic [3:0] MIN_TENS_MAX = 4'(MAX_MIN_TENS);
  localparam logic [3:0] ALARM_RELOAD = 4'(ALARM_CYCLES - 1);

  state_t     state, next_state;
  logic [3:0] alarm_cnt;
  logic       dec_step, count_is_zero, count_is_one, terminal, load_all_zero;
  logic       so_borrow, st_borrow, mo_borrow, mt_borrow;

  assign count_is_zero = (minute_tens == 4'd0) && (minute_ones == 4'd0) &&
                         (second_tens == 4'd0) && (second_ones == 4'd0);
  assign count_is_one  = (minute_tens == 4'd0) && (minute_ones == 4'd0) &&
                         (second_tens == 4'd0) && (second_ones == 4'd1);
  assign load_all_zero = (load_minute_tens == 4'd0) && (load_minute_ones == 4'd0) &&
                         (load_second_tens == 4'd0) && (load_second_ones == 4'd0);

  // One-second step; zero-detect gating keeps 00:00 from wrapping to 59:59
  assign dec_step = !enable_load && enable_timer_countdown && !count_is_zero &&
                    ((state == ARMED) || (state == COUNT));
  // A borrow out of minute tens can only be an underflow, so treat it as terminal too
  assign terminal = dec_step && (count_is_one || mt_borrow);

  bcd_down_digit u_second_ones (
    .clk(pulse_1Hz), .rst_n(reset_n), .load(enable_load), .load_value(load_second_ones),
    .dec(dec_step), .max_value(ONES_MAX), .digit(second_ones), .borrow_out(so_borrow)
  );
  bcd_down_digit u_second_tens (
    .clk(pulse_1Hz), .rst_n(reset_n), .load(enable_load), .load_value(load_second_tens),
    .dec(so_borrow), .max_value(SEC_TENS_MAX), .digit(second_tens), .borrow_out(st_borrow)
  );
  bcd_down_digit u_minute_ones (
    .clk(pulse_1Hz), .rst_n(reset_n), .load(enable_load), .load_value(load_minute_ones),
    .dec(st_borrow), .max_value(ONES_MAX), .digit(minute_ones), .borrow_out(mo_borrow)
  );
  bcd_down_digit u_minute_tens (
    .clk(pulse_1Hz), .rst_n(reset_n), .load(enable_load), .load_value(load_minute_tens),
    .dec(mo_borrow), .max_value(MIN_TENS_MAX), .digit(minute_tens), .borrow_out(mt_borrow)
  );

  // State register
  always_ff @(posedge pulse_1Hz or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: load from any state, otherwise arm -> count -> done
  always_comb begin
    next_state = state;
    if (enable_load) begin
      next_state = load_all_zero ? IDLE : ARMED;
    end else if (terminal) begin
      next_state = DONE;
    end else if ((state == ARMED) && enable_timer_countdown) begin
      next_state = COUNT;
    end
  end

  // Registered status outputs and alarm hold counter
  always_ff @(posedge pulse_1Hz or negedge reset_n) begin
    if (!reset_n) begin
      cook_time <= 1'b0;
      alarm     <= 1'b0;
      alarm_cnt <= 4'd0;
      running   <= 1'b0;
    end else begin
      running <= (next_state == COUNT);
      if (enable_load) begin
        cook_time <= 1'b0;
        alarm     <= 1'b0;
        alarm_cnt <= 4'd0;
      end else if (terminal) begin
        cook_time <= 1'b1;
        alarm     <= 1'b1;
        alarm_cnt <= ALARM_RELOAD;
      end else if (state == DONE) begin
        if (alarm_cnt != 4'd0) begin
          alarm_cnt <= alarm_cnt - 4'd1;
        end else begin
          alarm <= 1'b0;
        end
      end
    end
  end

endmodule
